aes_decipher_multi: RTL and testbench

Iterative AES inverse cipher core supporting AES-128, AES-192 and AES-256. It generalises the single-key-length decipher with a 2-bit key-length select, valid/ready handshakes on both sides, and a parametrised number of inverse S-box lanes that trades area for cycles per round. The core sits between the key-expansion RAM and the block datapath. It requests each round key by index and samples that key from an external zero-latency lookup.

---
 rtl/aes_decipher_multi.sv | 214 +++++++++++++++++++++
 tb/tb_aes_decipher_multi.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_multi.sv
// Iterative AES-128/192/256 inverse cipher with SBOX_LANES inverse S-boxes (16/SBOX_LANES cycles per round).
// Optional abort input enabled by defining AES_DEC_ABORT_EN.
module aes_decipher_multi #(
    parameter int SBOX_LANES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   keylen,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [127:0] new_block,
    output logic         err,
    output logic         out_valid,
    input  logic         out_ready
`ifdef AES_DEC_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam int unsigned LANES   = SBOX_LANES;
    localparam int unsigned P       = 16 / LANES;
    localparam logic [1:0]  LAST_PH = 2'(P - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_FINAL, ST_DONE} state_t;

    state_t         r_state;
    logic [1:0]     r_phase;
    logic [127:0]   r_st;
    logic [127:0]   r_sub;
    logic [127:0]   r_new_block;
    logic [3:0]     r_round;
    logic           r_err;
    logic           r_out_valid;

    logic [127:0]   w_shifted;
    logic [127:0]   w_sub_full;
    logic [7:0]     w_lane_in  [LANES];
    logic [7:0]     w_lane_out [LANES];
    logic           w_last;
    logic           w_take;
    logic           w_abort;
    logic           w_busy;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = s[127 - 8*(r + 4*c) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        return 4'd10 + {1'b0, kl, 1'b0};
    endfunction

    assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    assign w_take    = in_valid & in_ready;
    assign w_last    = (r_phase == LAST_PH);
    assign w_busy    = (r_state == ST_LOAD) | (r_state == ST_ROUND) | (r_state == ST_FINAL);
`ifdef AES_DEC_ABORT_EN
    assign w_abort   = abort & w_busy;
`else
    assign w_abort   = 1'b0;
`endif

    assign round     = r_round;
    assign new_block = r_new_block;
    assign err       = r_err;
    assign out_valid = r_out_valid;

    // Each lane muxes its byte by phase, so only LANES S-boxes exist; earlier phases come from r_sub.
    always_comb begin
        w_shifted  = inv_shift_rows(r_st);
        w_sub_full = r_sub;
        for (int unsigned j = 0; j < LANES; j++) begin
            w_lane_in[j] = '0;
            for (int unsigned ph = 0; ph < P; ph++) begin
                if (r_phase == 2'(ph)) w_lane_in[j] = w_shifted[127 - 8*(ph*LANES + j) -: 8];
            end
            w_lane_out[j] = inv_sbox(w_lane_in[j]);
            for (int unsigned ph = 0; ph < P; ph++) begin
                if (r_phase == 2'(ph)) w_sub_full[127 - 8*(ph*LANES + j) -: 8] = w_lane_out[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_st        <= '0;
            r_sub       <= '0;
            r_new_block <= '0;
            r_round     <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_round <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (r_state == ST_DONE && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                    if (w_take) begin
                        if (keylen == 2'b11) begin
                            r_state     <= ST_DONE;
                            r_new_block <= '0;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                            r_st    <= block;
                            r_round <= nr_of(keylen);
                        end
                    end
                end
                ST_LOAD: begin
                    r_st    <= r_st ^ round_key;
                    r_round <= r_round - 4'd1;
                    r_phase <= '0;
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (!w_last) begin
                        r_phase <= r_phase + 2'd1;
                        r_sub   <= w_sub_full;
                    end else begin
                        r_phase <= '0;
                        r_st    <= inv_mix(w_sub_full ^ round_key);
                        r_round <= r_round - 4'd1;
                        if (r_round == 4'd1) r_state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    if (!w_last) begin
                        r_phase <= r_phase + 2'd1;
                        r_sub   <= w_sub_full;
                    end else begin
                        r_phase     <= '0;
                        r_new_block <= w_sub_full ^ round_key;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decipher_multi.sv
// Directed bench for aes_decipher_multi: one instance with 16 S-box lanes, one with 4.
// Round keys come from a FIPS-197 key schedule computed here; plaintexts are the FIPS-197 constants.
module tb_aes_decipher_multi;

    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv   [2];
    logic         ir   [2];
    logic         ov   [2];
    logic         ordy [2];
    logic         er   [2];
    logic [1:0]   kl   [2];
    logic [1:0]   ksel [2];
    logic [127:0] blk  [2];
    logic [127:0] rk   [2];
    logic [127:0] nb   [2];
    logic [3:0]   rnd  [2];
`ifdef AES_DEC_ABORT_EN
    logic         ab   [2];
`endif
    logic [127:0] sched [4][16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // zero-latency round-key lookup
    always_comb begin
        rk[0] = sched[ksel[0]][rnd[0]];
        rk[1] = sched[ksel[1]][rnd[1]];
    end

    aes_decipher_multi #(.SBOX_LANES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .keylen(kl[0]),
        .block(blk[0]), .round(rnd[0]), .round_key(rk[0]), .new_block(nb[0]), .err(er[0]),
        .out_valid(ov[0]), .out_ready(ordy[0])
`ifdef AES_DEC_ABORT_EN
        , .abort(ab[0])
`endif
    );

    aes_decipher_multi #(.SBOX_LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .keylen(kl[1]),
        .block(blk[1]), .round(rnd[1]), .round_key(rk[1]), .new_block(nb[1]), .err(er[1]),
        .out_valid(ov[1]), .out_ready(ordy[1])
`ifdef AES_DEC_ABORT_EN
        , .abort(ab[1])
`endif
    );

    function automatic logic [7:0] tb_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = tb_xt(x);
        end
        return p;
    endfunction

    // forward S-box: brute-force inverse followed by the affine map
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] v = '0;
        for (int i = 1; i < 256; i++) if (tb_mul(x, 8'(i)) == 8'h01) v = 8'(i);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    task automatic build_sched(input int kli);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int nk = 4 + 2*kli;
        int nr = 10 + 2*kli;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = tb_xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) sched[kli][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int k, input logic [1:0] kli, input logic [127:0] ct);
        ksel[k] = kli;
        kl[k]   = kli;
        blk[k]  = ct;
        iv[k]   = 1'b1;
        chki("in_ready_take", int'(ir[k]), 1);
        tick();
        iv[k]   = 1'b0;
    endtask

    task automatic wait_ov(input int k, input int limit, output int n);
        n = 0;
        while (ov[k] !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic release_out(input int k);
        ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
        chki("out_valid_clr", int'(ov[k]), 0);
        chki("err_clr", int'(er[k]), 0);
    endtask

    // n counts edges after the transfer edge; round expected Nr at n=0, then Nr-1 (xP) ... 0
    task automatic run_vec(input int k, input logic [1:0] kli, input logic [127:0] ct,
                           input logic [127:0] pt, input logic erx, input int lat);
        int n;
        int rbad = 0;
        int p    = (k == 0) ? 1 : 4;
        int nr   = 10 + 2*int'(kli);
        int rexp;
        ordy[k] = 1'b0;
        start(k, kli, ct);
        blk[k] = {$urandom, $urandom, $urandom, $urandom};
        kl[k]  = 2'($urandom_range(0, 3));
        for (n = 0; n <= 200; n++) begin
            if (kli == 2'b11)  rexp = 0;
            else if (n == 0)   rexp = nr;
            else               rexp = nr - 1 - (n - 1) / p;
            if (rexp < 0) rexp = 0;
            if (rnd[k] !== 4'(rexp)) rbad++;
            if (ov[k] === 1'b1) break;
            tick();
        end
        chki("latency", n, lat);
        chki("round_seq", rbad, 0);
        chk("new_block", nb[k], pt);
        chki("err", int'(er[k]), int'(erx));
        release_out(k);
    endtask

    typedef struct {
        int           k;
        logic [1:0]   kl;
        logic [127:0] ct;
        logic [127:0] pt;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vt [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int got;
        int bad;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; kl[k] = '0; ksel[k] = '0; blk[k] = '0;
`ifdef AES_DEC_ABORT_EN
            ab[k] = 1'b0;
`endif
        end
        for (int a = 0; a < 4; a++) for (int r = 0; r < 16; r++) sched[a][r] = '0;
        for (int a = 0; a < 3; a++) build_sched(a);

        vt[0] = '{0, 2'd0, CT128, PT, 1'b0, 11};
        vt[1] = '{1, 2'd1, CT192, PT, 1'b0, 49};
        vt[2] = '{1, 2'd2, CT256, PT, 1'b0, 57};
        vt[3] = '{0, 2'd3, CT256, '0, 1'b1, 0};
        vt[4] = '{0, 2'd0, CT128, PT, 1'b0, 11};
        vt[5] = '{0, 2'd1, CT192, PT, 1'b0, 13};
        vt[6] = '{0, 2'd2, CT256, PT, 1'b0, 15};
        vt[7] = '{1, 2'd3, CT128, '0, 1'b1, 0};
        vt[8] = '{1, 2'd0, CT128, PT, 1'b0, 41};

        #23 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chki("rst_in_ready", int'(ir[k]), 1);
            chki("rst_out_valid", int'(ov[k]), 0);
            chki("rst_err", int'(er[k]), 0);
            chki("rst_round", int'(rnd[k]), 0);
            chk("rst_new_block", nb[k], '0);
        end

        foreach (vt[i]) run_vec(vt[i].k, vt[i].kl, vt[i].ct, vt[i].pt, vt[i].err, vt[i].lat);

        // back-to-back on the 16-lane core, in_valid and out_ready held high
        ordy[0] = 1'b1;
        start(0, 2'd0, CT128);
        iv[0] = 1'b1;
        got = 0;
        for (n = 0; n <= 100; n++) begin
            if (ov[0] === 1'b1) begin
                got++;
                chki("b2b_edge", n, 11 + 12*(got - 1));
                chk("b2b_block", nb[0], PT);
                chki("b2b_in_ready", int'(ir[0]), 1);
                if (got == 3) iv[0] = 1'b0;
            end
            if (got == 3) break;
            tick();
        end
        chki("b2b_count", got, 3);
        tick();
        ordy[0] = 1'b0;
        chki("b2b_idle", int'(ov[0]), 0);

        // backpressure, then simultaneous output and input transfer
        start(0, 2'd0, CT128);
        wait_ov(0, 100, n);
        chki("bp_latency", n, 11);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (nb[0] !== PT || ov[0] !== 1'b1 || ir[0] !== 1'b0 || er[0] !== 1'b0) bad++;
        end
        chki("bp_hold", bad, 0);
        ksel[0] = 2'd1; kl[0] = 2'd1; blk[0] = CT192; iv[0] = 1'b1; ordy[0] = 1'b1;
        #1;
        chki("bp_in_ready_rise", int'(ir[0]), 1);
        tick();
        iv[0] = 1'b0; ordy[0] = 1'b0;
        chki("bp_out_taken", int'(ov[0]), 0);
        chki("bp_in_taken_round", int'(rnd[0]), 12);
        wait_ov(0, 100, n);
        chki("bp_latency2", n, 13);
        chk("bp_block2", nb[0], PT);
        release_out(0);

        // asynchronous reset in round 5 on the 4-lane core
        start(1, 2'd0, CT128);
        n = 0;
        while (rnd[1] !== 4'd5 && n < 100) begin
            tick();
            n++;
        end
        chki("rst_reach_round5", int'(rnd[1] === 4'd5), 1);
        #2 rst_n = 1'b0;
        #1;
        chki("midrst_in_ready", int'(ir[1]), 1);
        chki("midrst_round", int'(rnd[1]), 0);
        chki("midrst_out_valid", int'(ov[1]), 0);
        #2 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (ov[1] !== 1'b0 || ov[0] !== 1'b0) bad++;
        end
        chki("midrst_no_out", bad, 0);
        run_vec(1, 2'd0, CT128, PT, 1'b0, 41);

`ifdef AES_DEC_ABORT_EN
        start(1, 2'd2, CT256);
        n = 0;
        while (rnd[1] !== 4'd7 && n < 100) begin
            tick();
            n++;
        end
        chki("abort_reach_round7", int'(rnd[1] === 4'd7), 1);
        ab[1] = 1'b1;
        tick();
        ab[1] = 1'b0;
        chki("abort_round", int'(rnd[1]), 0);
        chki("abort_in_ready", int'(ir[1]), 1);
        bad = 0;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (ov[1] !== 1'b0) bad++;
        end
        chki("abort_no_out", bad, 0);
        ab[1] = 1'b1;
        start(1, 2'd0, CT128);
        ab[1] = 1'b0;
        chki("abort_idle_take", int'(rnd[1]), 10);
        wait_ov(1, 100, n);
        chki("abort_idle_latency", n, 41);
        chk("abort_idle_block", nb[1], PT);
        release_out(1);
        run_vec(1, 2'd2, CT256, PT, 1'b0, 57);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
